// File: rtl/i2c_reg_bank_if.sv
// Byte-level handshake between an I2C slave core and the register bank.
// The master modport is the slave core; the slave modport is the register bank.
interface i2c_reg_bank_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       tx_ready;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport master (
    output rx_data, rx_valid, rx_active, tx_ready, tx_busy,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, rx_active, tx_ready, tx_busy,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/i2c_reg_bank.sv
// I2C-addressable register bank: the first byte of a master write sets the pointer,
// later bytes are stored with auto-increment; reads stream regs[ptr] with prefetch.
module i2c_reg_bank #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned PTR_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  i2c_reg_bank_if.slave     bus,
  input  logic [PTR_W-1:0]  host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_we,
  output logic [7:0]        host_rdata,
  output logic              upd_strobe,
  output logic [PTR_W-1:0]  upd_addr
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {IDLE, PTR, WDATA} state_t;

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic                armed;
  logic                rx_active_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                rx_rise_c;
  logic                rx_fall_c;
  logic                rx_ptr_c;
  logic                rx_wr_c;
  logic                tx_accept_c;
  logic [PTR_W-1:0]    ptr_inc_c;

  assign rx_rise_c   = ~rx_active_q & bus.rx_active;
  assign rx_fall_c   = rx_active_q & ~bus.rx_active;
  assign rx_ptr_c    = (state == PTR) & bus.rx_valid;
  assign rx_wr_c     = (state == WDATA) & bus.rx_valid;
  assign ptr_inc_c   = ptr + PTR_W'(1);
  // A received byte owns the pointer in its cycle; a read accept waits.
  assign tx_accept_c = bus.tx_valid & bus.tx_ready & ~(rx_ptr_c | rx_wr_c);

  assign bus.tx_valid = armed & ~bus.rx_active;
  assign bus.tx_data  = regs[ptr];
  assign host_rdata   = regs[host_addr];

  // rx_active_q resets high so a transaction already in flight at reset
  // release must drop and rise again before it is honoured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      armed       <= 1'b1;
      rx_active_q <= 1'b1;
      upd_strobe  <= 1'b0;
      upd_addr    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[PTR_W'(i)] <= '0;
      end
    end else begin
      rx_active_q <= bus.rx_active;
      upd_strobe  <= rx_wr_c;

      if (host_we) begin
        regs[host_addr] <= host_wdata;
      end
      // Placed after the host write so an I2C write to the same address wins.
      if (rx_wr_c) begin
        regs[ptr] <= bus.rx_data;
        upd_addr  <= ptr;
      end

      case (state)
        IDLE: begin
          if (rx_rise_c) begin
            state <= PTR;
          end
        end
        PTR: begin
          if (bus.rx_valid) begin
            ptr   <= bus.rx_data[PTR_W-1:0];
            state <= WDATA;
          end
        end
        WDATA: begin
          if (bus.rx_valid) begin
            ptr <= ptr_inc_c;
          end
        end
        default: state <= IDLE;
      endcase

      if ((state != IDLE) && rx_fall_c) begin
        state <= IDLE;
      end

      if (tx_accept_c) begin
        ptr   <= ptr_inc_c;
        armed <= bus.tx_busy;
      end
      if (rx_fall_c) begin
        armed <= 1'b1;
      end
    end
  end

endmodule
